// File: rtl/sm_integrate_dump.sv
// Integrate-and-dump accumulator for 5-bit sign-magnitude mixer products.
// Window sums are delivered through a one-deep valid/ready result register.
module sm_integrate_dump #(
  parameter int ACC_WIDTH = 24,
  parameter int CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        sample_valid,
  input  logic [4:0]                  sample,
  input  logic                        dump,
  input  logic                        clear,
  output logic signed [ACC_WIDTH-1:0] acc_out,
  output logic [CNT_WIDTH-1:0]        acc_count,
  output logic                        acc_ovf,
  output logic                        acc_valid,
  input  logic                        acc_ready,
  output logic                        dropped
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t                       state;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic [CNT_WIDTH-1:0]         cnt;
  logic                         ovf;

  logic [ACC_WIDTH:0]           mag_ext;
  logic signed [ACC_WIDTH:0]    value_ext;
  logic signed [ACC_WIDTH:0]    sum_wide;
  logic signed [ACC_WIDTH-1:0]  sum_sat;
  logic                         sat_hit;
  logic [CNT_WIDTH-1:0]         cnt_next;

  // One extra bit of headroom makes overflow visible as a top-two-bit disagreement.
  always_comb begin
    mag_ext   = {{(ACC_WIDTH-3){1'b0}}, sample[3:0]};
    value_ext = '0;
    if (sample_valid) begin
      value_ext = sample[4] ? -$signed(mag_ext) : $signed(mag_ext);
    end
    sum_wide = $signed({acc[ACC_WIDTH-1], acc}) + value_ext;
    sat_hit  = sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1];
    sum_sat  = sum_wide[ACC_WIDTH-1:0];
    if (sat_hit) begin
      sum_sat = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
    cnt_next = cnt;
    if (sample_valid && (cnt != '1)) begin
      cnt_next = cnt + CNT_WIDTH'(1);
    end
  end

  assign acc_valid = (state == FULL);

  // Clear wins over dump; a dump folds this cycle's sample into the result
  // and restarts the window so no sample is lost across the boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      acc_out   <= '0;
      acc_count <= '0;
      acc_ovf   <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      dropped <= 1'b0;
      if (clear) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
        if (state == FULL && acc_ready) state <= EMPTY;
      end else if (dump) begin
        acc_out   <= sum_sat;
        acc_count <= cnt_next;
        acc_ovf   <= ovf | sat_hit;
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
        if (state == FULL && !acc_ready) dropped <= 1'b1;
        state <= FULL;
      end else begin
        acc <= sum_sat;
        cnt <= cnt_next;
        ovf <= ovf | sat_hit;
        if (state == FULL && acc_ready) state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_sm_integrate_dump.sv
// Self-checking bench for sm_integrate_dump: directed steps plus random traffic
// compared each cycle against an integer window model.
module tb_sm_integrate_dump;

  localparam int AW = 6;
  localparam int CW = 16;
  localparam int ACC_MAX = (1 << (AW-1)) - 1;
  localparam int ACC_MIN = -(1 << (AW-1));
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sample_valid = 1'b0;
  logic [4:0]    sample = '0;
  logic          dump = 1'b0;
  logic          clear = 1'b0;
  logic          acc_ready = 1'b0;
  logic [AW-1:0] acc_out;
  logic [CW-1:0] acc_count;
  logic          acc_ovf;
  logic          acc_valid;
  logic          dropped;

  int checks = 0;
  int errors = 0;

  // Reference model: window sum, sample count, window overflow, result slot
  int m_acc, m_cnt, m_ovf;
  int m_out, m_count, m_rovf, m_valid, m_dropped;

  sm_integrate_dump #(.ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample(sample),
    .dump(dump), .clear(clear), .acc_out(acc_out), .acc_count(acc_count),
    .acc_ovf(acc_ovf), .acc_valid(acc_valid), .acc_ready(acc_ready), .dropped(dropped)
  );

  always #5 clk = ~clk;

  function automatic int clamp(input int x);
    if (x > ACC_MAX) return ACC_MAX;
    if (x < ACC_MIN) return ACC_MIN;
    return x;
  endfunction

  task automatic modelReset();
    m_acc = 0; m_cnt = 0; m_ovf = 0;
    m_out = 0; m_count = 0; m_rovf = 0; m_valid = 0; m_dropped = 0;
  endtask

  task automatic modelEdge();
    int val, raw, s, c;
    val = 0;
    if (sample_valid) val = sample[4] ? -int'(sample[3:0]) : int'(sample[3:0]);
    m_dropped = 0;
    if (clear) begin
      m_acc = 0; m_cnt = 0; m_ovf = 0;
      if (m_valid && acc_ready) m_valid = 0;
    end else begin
      raw = m_acc + val;
      s   = clamp(raw);
      c   = (sample_valid && m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
      if (dump) begin
        if (m_valid && !acc_ready) m_dropped = 1;
        m_out = s; m_count = c; m_rovf = (m_ovf || raw != s) ? 1 : 0;
        m_valid = 1;
        m_acc = 0; m_cnt = 0; m_ovf = 0;
      end else begin
        m_acc = s; m_cnt = c;
        if (raw != s) m_ovf = 1;
        if (m_valid && acc_ready) m_valid = 0;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [AW-1:0] exp_out;
    logic [CW-1:0] exp_count;
    exp_out   = m_out[AW-1:0];
    exp_count = m_count[CW-1:0];
    checks++;
    assert (acc_out === exp_out) else begin
      errors++;
      $error("[TB] FAIL %s acc_out observed=%0d expected=%0d", tag, $signed(acc_out), m_out);
    end
    checks++;
    assert (acc_count === exp_count) else begin
      errors++;
      $error("[TB] FAIL %s acc_count observed=%0d expected=%0d", tag, acc_count, m_count);
    end
    checks++;
    assert (acc_ovf === m_rovf[0]) else begin
      errors++;
      $error("[TB] FAIL %s acc_ovf observed=%b expected=%0d", tag, acc_ovf, m_rovf);
    end
    checks++;
    assert (acc_valid === m_valid[0]) else begin
      errors++;
      $error("[TB] FAIL %s acc_valid observed=%b expected=%0d", tag, acc_valid, m_valid);
    end
    checks++;
    assert (dropped === m_dropped[0]) else begin
      errors++;
      $error("[TB] FAIL %s dropped observed=%b expected=%0d", tag, dropped, m_dropped);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then check just after it.
  task automatic applyStimulus(input logic v, input logic [4:0] s, input logic d,
                               input logic c, input logic r, input string tag);
    sample_valid = v; sample = s; dump = d; clear = c; acc_ready = r;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  task automatic resetPulse(input string tag);
    #2 reset_n = 1'b0;
    modelReset();
    #1 checkOutput(tag);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    modelReset();
    #2 checkOutput("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Windowed sum: 9 - 2 + 3 + 0 = 10
    applyStimulus(1, 5'h09, 0, 0, 1, "win_s0");
    applyStimulus(1, 5'h12, 0, 0, 1, "win_s1");
    applyStimulus(1, 5'h03, 0, 0, 1, "win_s2");
    applyStimulus(1, 5'h10, 1, 0, 1, "win_dump");
    applyStimulus(0, 5'h00, 0, 0, 1, "win_drain");

    // Continuity across back-to-back windows of three
    for (int i = 0; i < 9; i++)
      applyStimulus(1, 5'h01, (i % 3) == 2, 0, 1, "cont");
    applyStimulus(0, 5'h00, 0, 0, 1, "cont_idle");

    // Backpressure: 7 then -5 overwrites with a drop
    applyStimulus(1, 5'h07, 1, 0, 0, "bp_dump7");
    applyStimulus(1, 5'h15, 1, 0, 0, "bp_dump_m5");
    applyStimulus(0, 5'h00, 0, 0, 0, "bp_hold");
    applyStimulus(0, 5'h00, 0, 0, 1, "bp_drain");
    applyStimulus(0, 5'h00, 0, 0, 1, "bp_empty");

    // Positive then negative saturation, with ovf cleared for the next window
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 5'h09, i == 3, 0, 1, "sat_pos");
    applyStimulus(1, 5'h01, 1, 0, 1, "sat_next");
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 5'h19, i == 3, 0, 1, "sat_neg");
    applyStimulus(0, 5'h00, 0, 0, 1, "sat_idle");

    // Clear/dump collision produces nothing; next window starts from zero
    applyStimulus(1, 5'h06, 0, 0, 1, "cd_acc");
    applyStimulus(1, 5'h05, 1, 1, 1, "cd_collide");
    applyStimulus(1, 5'h02, 1, 0, 1, "cd_next");
    applyStimulus(0, 5'h00, 0, 0, 1, "cd_idle");

    // Async reset while FULL and mid-window
    applyStimulus(1, 5'h03, 1, 0, 0, "rst_fill");
    applyStimulus(1, 5'h05, 0, 0, 0, "rst_mid");
    resetPulse("rst_async");
    applyStimulus(1, 5'h04, 1, 0, 1, "rst_after");
    applyStimulus(0, 5'h00, 0, 0, 1, "rst_idle");

    // Random traffic against the model
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 1) == 1, "rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sm_integrate_dump.md
# sm_integrate_dump

Integrate-and-dump accumulator that consumes the 5-bit sign-magnitude products of the carrier/signal mixer multiplier and sums them over a correlation window. On each `dump` strobe (typically the code-epoch boundary), it delivers a two's-complement window sum through a valid/ready output register and restarts integration without losing samples. One instance sits behind each mixer output (I or Q) in a tracking channel.

## Interface
Parameters:
- `ACC_WIDTH`, 24: accumulator and result width, signed two's complement.
- `CNT_WIDTH`, 16: sample-counter width.

Ports:
- `clk` input 1: clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `sample_valid` input 1: `sample` is valid this cycle.
- `sample` input 5: sign-magnitude product. Bit 4 is the sign (1 = negative); bits 3:0 are the magnitude.
- `dump` input 1: closes the current window. The sample in the same cycle is included.
- `clear` input 1: discards the current window.
- `acc_out` output ACC_WIDTH: dumped window sum.
- `acc_count` output CNT_WIDTH: number of valid samples in the dumped window.
- `acc_ovf` output 1: saturation occurred in the dumped window.
- `acc_valid` output 1: result register holds an unread result.
- `acc_ready` input 1: consumer accepts the result.
- `dropped` output 1: one-cycle pulse when an unread result is overwritten.

## Operation
- Conversion: value = +mag when bit4=0, and −mag when bit4=1. Negative zero (5'b10000) counts as 0. Magnitudes 10–15 are accumulated unchanged, with no range check.
- Running state: `acc` (ACC_WIDTH, signed), `cnt` (CNT_WIDTH), and a window `ovf` flag.
- Each cycle with `sample_valid`=1 and `clear`=0:
  - `acc` ← sat(`acc` + value).
  - `cnt` ← `cnt` + 1. `cnt` saturates at all-ones.
- Saturation: `acc` clamps at +2^(ACC_WIDTH−1)−1 or −2^(ACC_WIDTH−1). Any clamp sets `ovf` for the window.
- Dump (`dump`=1, `clear`=0):
  - The result register loads sat(`acc` + this-cycle value), the matching count, and `ovf`, including any saturation caused by this cycle's sample.
  - Next cycle, `acc`, `cnt` and `ovf` are 0, so the next window starts cleanly.
  - A `dump` with no valid samples in the window yields `acc_out`=0 and `acc_count`=0.
- Clear (`clear`=1):
  - `acc`, `cnt` and `ovf` go to 0, and the sample in this cycle is discarded.
  - `clear` has priority over `dump`: no result is produced and the result register is untouched.
- Output register FSM, with states EMPTY (`acc_valid`=0) and FULL (`acc_valid`=1):
  - EMPTY + dump → FULL.
  - FULL + `acc_ready` with no dump → EMPTY.
  - FULL + `acc_ready` + dump → FULL with the new result. `dropped` stays 0.
  - FULL + no `acc_ready` + dump → FULL with the new result overwriting the old one, and a one-cycle pulse on `dropped`.
- `acc_out`, `acc_count` and `acc_ovf` hold stable while `acc_valid`=1 and no new dump occurs.

## Timing
- Reset (`reset_n`=0, asynchronous):
  - `acc_out`=0, `acc_count`=0, `acc_ovf`=0, `acc_valid`=0, `dropped`=0.
  - Internal `acc`, `cnt` and `ovf` are 0, and the FSM is in EMPTY.
- Release: the first rising edge after `reset_n` rises is a normal cycle.
- Reset mid-window or with FULL asserted: the partial sum and any unread result are lost. No `dropped` pulse is generated.
- Latency: `dump` sampled at edge N gives `acc_valid`=1 with the result on outputs after edge N (one-cycle latency).
- The sample at edge N+1 belongs to the new window. Back-to-back dumps on consecutive cycles are legal, and each window contains exactly one cycle.
- Transfer occurs at an edge where `acc_valid`=1 and `acc_ready`=1.
- `acc_ready` may be high while EMPTY, with no effect.
- `dropped` asserts on the edge after the overwriting dump and lasts exactly one cycle.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Reset then windowed sum:
  - Stimulus: 4 valid samples 5'h09, 5'h12, 5'h03, 5'h10, with `dump` on the 4th sample and `acc_ready`=1.
  - Required response: `acc_out`=10 (9 − 2 + 3 + 0), `acc_count`=4, `acc_ovf`=0, and `acc_valid` high for exactly 1 cycle.
- Continuity across dump:
  - Stimulus: samples of +1 every cycle, with `dump` every 3rd cycle.
  - Required response: every result is 3 with `acc_count`=3; no sample is lost or double-counted.
- Backpressure:
  - Stimulus: `acc_ready`=0, dump giving 7, then dump giving −5.
  - Required response: `acc_out` goes 7 → −5, `dropped` pulses once, `acc_valid` stays 1. Raising `acc_ready` drains the register to EMPTY.
- Saturation, with ACC_WIDTH=6:
  - Stimulus: 4 samples of +9.
  - Required response: `acc_out`=31, `acc_ovf`=1, and the next window `ovf`=0.
  - Repeat with −9 samples: `acc_out`=−32.
- Clear/dump collision:
  - Stimulus: accumulate 6, then assert `clear` and `dump` together; follow with sample +2 and dump.
  - Required response: no result from the collision cycle; the next result is 2 with `acc_count`=1.
- Async reset while FULL and mid-window:
  - Stimulus: pulse `reset_n` low between edges.
  - Required response: all outputs 0 immediately. The next dump after a sample +4 gives 4.
